sad_accumulator: RTL and testbench
==================================

# sad_accumulator

Streaming consumer for the SAD datapath: takes the 16-bit absolute-difference values produced by the absolute-value stage, sums them over a fixed-length block per motion candidate, and tracks the candidate with the minimum sum. It sits directly downstream of the absolute-value stage. It reports the best candidate index and its SAD to the search controller when a full search completes.

## Interface
- DATA_W, 16, width of each absolute-difference sample
- ACC_W, 24, accumulator and SAD result width
- BLOCK_LEN, 64, samples summed per candidate (≥2)
- NUM_CAND, 16, candidates per search (≥1)
- IDX_W, 4, candidate index width (≥ clog2(NUM_CAND))
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a search; sampled only in IDLE
- abs_in  in  DATA_W  unsigned absolute-difference sample
- abs_valid  in  1  abs_in valid this cycle
- abs_ready  out  1  block accepts a sample this cycle
- busy  out  1  search in progress (any state other than IDLE)
- sad_out  out  ACC_W  SAD of the most recently completed candidate
- best_sad  out  ACC_W  minimum SAD of the search so far
- best_idx  out  IDX_W  index of the candidate holding best_sad
- done  out  1  one-cycle pulse: search complete, results valid

## Operation
- FSM states: IDLE, ACCUM, COMPARE, DONE.
- IDLE:
  - abs_ready=0, busy=0.
  - start=1 → clear acc, sample count and cand count; set best_sad to all-ones and best_idx to 0; go to ACCUM.
- ACCUM:
  - abs_ready=1.
  - A beat is accepted when abs_valid & abs_ready. On a beat: acc ← acc + abs_in, saturating at 2^ACC_W−1, and sample count increments.
  - On the beat that makes the count reach BLOCK_LEN, go to COMPARE.
- COMPARE (one cycle):
  - abs_ready=0; sad_out ← acc.
  - If acc < best_sad (strict), then best_sad ← acc and best_idx ← cand. On a tie, the earlier index is kept.
  - If cand == NUM_CAND−1, go to DONE. Otherwise cand++, acc ← 0, sample count ← 0, go to ACCUM.
- DONE (one cycle): done=1, abs_ready=0, then go to IDLE.
- After DONE, sad_out, best_sad and best_idx hold until the next accepted start.
- start is ignored outside IDLE. abs_valid is ignored when abs_ready=0, and no data is consumed.
- Width rule: abs_in is zero-extended to ACC_W before the add. Saturation is sticky for that candidate's sum.

## Timing
- Reset values: state IDLE, abs_ready=0, busy=0, done=0, sad_out=0, best_sad=0, best_idx=0, all counters 0.
- Reset asserted mid-search aborts immediately; no done pulse is produced.
- start sampled at edge t → ACCUM from t+1; abs_ready=1 and busy=1 during cycle t+1.
- Last beat of a candidate accepted at edge t → COMPARE in cycle t+1 → sad_out and best_* updated at edge t+2.
- Between candidates there is exactly one bubble cycle (abs_ready=0 during COMPARE).
- Last beat of the final candidate at edge t → done high during cycle t+2 → IDLE at t+3.
- A start asserted during the done cycle is ignored. Earliest new start is sampled at t+3.
- Throughput: one sample per cycle within a candidate. abs_valid gaps stall without loss.

## Test plan
(BLOCK_LEN=4, NUM_CAND=3, ACC_W=24 unless stated.)
- Basic search: candidate samples {1,2,3,4}, {0,0,1,0}, {5,5,5,5} at full rate.
  - Required: sad_out sequence 10, 1, 20.
  - done at the third candidate's last-beat edge +2, with best_sad=1 and best_idx=1.
- Tie: candidate sums 7, 7, 9.
  - Required: best_idx=0, best_sad=7.
- Backpressure/gaps: toggle abs_valid 1,0,0,1,… with values all 3.
  - Required: every sum is 12.
  - abs_ready=0 exactly in each COMPARE and the DONE cycle.
  - No extra or lost samples.
- Saturation (ACC_W=17): four samples of 0xFFFF.
  - Required: sad_out=0x1FFFF and no wrap.
- Reset mid-search: assert rst during the second candidate.
  - Required: all outputs at reset values next cycle; no done pulse.
  - A new start then produces a correct full search.
- Protocol: start pulses during ACCUM and during the done cycle are ignored.
  - Required: only one done per accepted start; busy deasserts the cycle after done.

Source files
------------

// File: rtl/sad_accumulator_if.sv
// Sample stream, search control and result bundle between the
// absolute-value stage / search controller and sad_accumulator.
interface sad_accumulator_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24,
    parameter int IDX_W  = 4
);
    logic              start;
    logic [DATA_W-1:0] abs_in;
    logic              abs_valid;
    logic              abs_ready;
    logic              busy;
    logic [ACC_W-1:0]  sad_out;
    logic [ACC_W-1:0]  best_sad;
    logic [IDX_W-1:0]  best_idx;
    logic              done;

    modport master (
        output start, abs_in, abs_valid,
        input  abs_ready, busy, sad_out, best_sad, best_idx, done
    );

    modport slave (
        input  start, abs_in, abs_valid,
        output abs_ready, busy, sad_out, best_sad, best_idx, done
    );
endinterface

// File: rtl/sad_accumulator.sv
// Sums BLOCK_LEN absolute differences per motion candidate (saturating) and
// tracks the lowest-SAD candidate over NUM_CAND candidates of one search.
module sad_accumulator #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 24,
    parameter int BLOCK_LEN = 64,
    parameter int NUM_CAND  = 16,
    parameter int IDX_W     = 4
) (
    input logic              clk,
    input logic              rst,
    sad_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(BLOCK_LEN + 1);

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(BLOCK_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_CAND   = IDX_W'(NUM_CAND - 1);
    localparam logic [ACC_W-1:0] ACC_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        COMPARE,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] sample_cnt;
    logic [IDX_W-1:0] cand;
    logic [ACC_W-1:0] sad_q;
    logic [ACC_W-1:0] best_sad_q;
    logic [IDX_W-1:0] best_idx_q;

    logic             beat;
    logic             last_beat;
    logic             last_cand;
    logic             better;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_sat;

    // One extra bit catches the carry out so the sum clamps instead of wrapping.
    assign acc_sum   = {1'b0, acc} + (ACC_W + 1)'(bus.abs_in);
    assign acc_sat   = acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];
    assign beat      = bus.abs_valid && bus.abs_ready;
    assign last_beat = beat && (sample_cnt == LAST_SAMPLE);
    assign last_cand = (cand == LAST_CAND);
    assign better    = (acc < best_sad_q);

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment at the top keeps this block purely
    // combinational; a path that leaves state_nxt unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = ACCUM;
            ACCUM:   if (last_beat) state_nxt = COMPARE;
            COMPARE: state_nxt = last_cand ? DONE : ACCUM;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.abs_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        unique case (state)
            IDLE:    bus.busy      = 1'b0;
            ACCUM:   bus.abs_ready = 1'b1;
            DONE:    bus.done      = 1'b1;
            default: ;
        endcase
    end

    // best_sad resets to 0 but is preloaded with all-ones at each start so
    // the first candidate always wins the strict compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            sample_cnt <= '0;
            cand       <= '0;
            sad_q      <= '0;
            best_sad_q <= '0;
            best_idx_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc        <= '0;
                        sample_cnt <= '0;
                        cand       <= '0;
                        best_sad_q <= ACC_MAX;
                        best_idx_q <= '0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc        <= acc_sat;
                        sample_cnt <= sample_cnt + CNT_W'(1);
                    end
                end
                COMPARE: begin
                    sad_q <= acc;
                    // Strict less-than keeps the earlier index on a tie.
                    if (better) begin
                        best_sad_q <= acc;
                        best_idx_q <= cand;
                    end
                    if (!last_cand) begin
                        cand       <= cand + IDX_W'(1);
                        acc        <= '0;
                        sample_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sad_out  = sad_q;
    assign bus.best_sad = best_sad_q;
    assign bus.best_idx = best_idx_q;
endmodule

// File: tb/tb_sad_accumulator.sv
// Self-checking bench for sad_accumulator: table-driven searches, randomized
// searches against a plain-arithmetic model, and hand-written corner sequences.
module tb_sad_accumulator;
    localparam int DATA_W    = 16;
    localparam int ACC_W     = 24;
    localparam int BLOCK_LEN = 4;
    localparam int NUM_CAND  = 3;
    localparam int IDX_W     = 4;
    localparam int N_SAMP    = BLOCK_LEN * NUM_CAND;
    localparam int SAT_ACC_W = 17;
    localparam int SAT_CAND  = 2;

    typedef struct packed {
        logic [N_SAMP*DATA_W-1:0]  samples;   // sample 0 in the top bits
        logic [1:0]                gap;       // 0 full rate, 1 valid 1-0-0, 2 random
        logic [NUM_CAND*ACC_W-1:0] sads;      // candidate 0 in the top bits
        logic [ACC_W-1:0]          best_sad;
        logic [IDX_W-1:0]          best_idx;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sad_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IDX_W(IDX_W)) bus ();
    sad_accumulator_if #(.DATA_W(DATA_W), .ACC_W(SAT_ACC_W), .IDX_W(IDX_W)) sbus ();

    sad_accumulator #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .BLOCK_LEN(BLOCK_LEN),
        .NUM_CAND(NUM_CAND), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    sad_accumulator #(
        .DATA_W(DATA_W), .ACC_W(SAT_ACC_W), .BLOCK_LEN(BLOCK_LEN),
        .NUM_CAND(SAT_CAND), .IDX_W(IDX_W)
    ) dut_sat (
        .clk(clk), .rst(rst), .bus(sbus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Passive observer: counts done pulses and stall cycles, and records the
    // SAD reported after every COMPARE cycle.
    int               done_cnt   = 0;
    int               bubble_cnt = 0;
    logic             prev_cmp   = 1'b0;
    logic [ACC_W-1:0] sad_hist[$];

    always @(negedge clk) begin
        if (rst) begin
            prev_cmp <= 1'b0;
        end else begin
            if (bus.done) done_cnt <= done_cnt + 1;
            if (bus.busy && !bus.abs_ready) bubble_cnt <= bubble_cnt + 1;
            if (prev_cmp) sad_hist.push_back(bus.sad_out);
            prev_cmp <= bus.busy && !bus.abs_ready && !bus.done;
        end
    end

    function automatic logic [DATA_W-1:0] samp(input logic [N_SAMP*DATA_W-1:0] flat, input int i);
        return flat[(N_SAMP-1-i)*DATA_W +: DATA_W];
    endfunction

    function automatic logic [ACC_W-1:0] exp_sad(input vec_t v, input int c);
        return v.sads[(NUM_CAND-1-c)*ACC_W +: ACC_W];
    endfunction

    function automatic vec_t mk(input logic [N_SAMP*DATA_W-1:0] flat, input logic [1:0] gap,
                                input logic [NUM_CAND*ACC_W-1:0] sads,
                                input logic [ACC_W-1:0] best, input logic [IDX_W-1:0] idx);
        vec_t v;
        v.samples  = flat;
        v.gap      = gap;
        v.sads     = sads;
        v.best_sad = best;
        v.best_idx = idx;
        return v;
    endfunction

    // Reference: each candidate's SAD is its plain sum clamped to the
    // accumulator range; the best is the first candidate with the smallest SAD.
    function automatic vec_t model(input logic [N_SAMP*DATA_W-1:0] flat, input logic [1:0] gap);
        vec_t   v;
        longint sum;
        longint max_val = (longint'(1) << ACC_W) - 1;
        longint best    = longint'(1) << ACC_W;
        int     bidx    = 0;
        v.samples = flat;
        v.gap     = gap;
        v.sads    = '0;
        for (int c = 0; c < NUM_CAND; c++) begin
            sum = 0;
            for (int k = 0; k < BLOCK_LEN; k++) sum += longint'(samp(flat, c*BLOCK_LEN + k));
            if (sum > max_val) sum = max_val;
            v.sads[(NUM_CAND-1-c)*ACC_W +: ACC_W] = ACC_W'(sum);
            if (sum < best) begin
                best = sum;
                bidx = c;
            end
        end
        v.best_sad = ACC_W'(best);
        v.best_idx = IDX_W'(bidx);
        return v;
    endfunction

    // Offers samples under the vector's valid pattern until n beats are
    // accepted; returns #1 after the edge that accepted the last one.
    task automatic send(input vec_t v, input int n, input bit poke_start);
        int idx = 0;
        int cyc = 0;
        bit took;
        while (idx < n && cyc < 400) begin
            case (v.gap)
                2'd0:    bus.abs_valid = 1'b1;
                2'd1:    bus.abs_valid = (cyc % 3 == 0);
                default: bus.abs_valid = 1'($urandom_range(0, 1));
            endcase
            bus.abs_in = bus.abs_valid ? samp(v.samples, idx) : DATA_W'($urandom);
            bus.start  = poke_start && (cyc == 2);
            took       = bus.abs_valid && bus.abs_ready;
            @(posedge clk);
            #1;
            if (took) idx++;
            cyc++;
        end
        bus.abs_valid = 1'b0;
        bus.start     = 1'b0;
        check("beats_accepted", 64'(idx), 64'(n));
    endtask

    task automatic run_search(input string tag, input vec_t v, input bit poke_accum, input bit poke_done);
        int d0 = done_cnt;
        int b0 = bubble_cnt;
        int q0 = sad_hist.size();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);
        check({tag, "_ready_after_start"}, 64'(bus.abs_ready), 64'd1);
        send(v, N_SAMP, poke_accum);
        // Final COMPARE cycle: one bubble, no done yet.
        check({tag, "_cmp_ready"}, 64'(bus.abs_ready), 64'd0);
        check({tag, "_cmp_done"}, 64'(bus.done), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd1);
        check({tag, "_done_ready"}, 64'(bus.abs_ready), 64'd0);
        check({tag, "_sad_out"}, 64'(bus.sad_out), 64'(exp_sad(v, NUM_CAND-1)));
        check({tag, "_best_sad"}, 64'(bus.best_sad), 64'(v.best_sad));
        check({tag, "_best_idx"}, 64'(bus.best_idx), 64'(v.best_idx));
        if (poke_done) bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_done_drop"}, 64'(bus.done), 64'd0);
        check({tag, "_busy_drop"}, 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_stay_idle"}, 64'(bus.busy), 64'd0);
        check({tag, "_hold_best"}, 64'(bus.best_sad), 64'(v.best_sad));
        check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_bubbles"}, 64'(bubble_cnt - b0), 64'(NUM_CAND + 1));
        check({tag, "_sad_reports"}, 64'(sad_hist.size() - q0), 64'(NUM_CAND));
        for (int c = 0; c < NUM_CAND; c++) begin
            if (q0 + c < sad_hist.size())
                check($sformatf("%s_sad%0d", tag, c), 64'(sad_hist[q0+c]), 64'(exp_sad(v, c)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    vec_t                     tbl[5];
    vec_t                     rv;
    logic [N_SAMP*DATA_W-1:0] flat;
    int                       d_base;
    int                       sat_idx;
    int                       sat_cyc;
    bit                       sat_took;

    initial begin
        bus.start      = 1'b0;
        bus.abs_valid  = 1'b0;
        bus.abs_in     = '0;
        sbus.start     = 1'b0;
        sbus.abs_valid = 1'b0;
        sbus.abs_in    = '0;
        rst            = 1'b1;

        tbl[0] = mk({16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd1, 16'd0, 16'd5, 16'd5, 16'd5, 16'd5},
                    2'd0, {24'd10, 24'd1, 24'd20}, 24'd1, 4'd1);
        tbl[1] = mk({16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd2, 16'd2, 16'd1, 16'd3, 16'd3, 16'd3, 16'd0},
                    2'd0, {24'd7, 24'd7, 24'd9}, 24'd7, 4'd0);
        tbl[2] = mk({16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3},
                    2'd1, {24'd12, 24'd12, 24'd12}, 24'd12, 4'd0);
        tbl[3] = mk({16'd10, 16'd10, 16'd10, 16'd10, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd4},
                    2'd2, {24'd40, 24'd5, 24'd4}, 24'd4, 4'd2);
        tbl[4] = mk({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE,
                     16'hFFFF, 16'd0, 16'd0, 16'd0},
                    2'd0, {24'd262140, 24'd262139, 24'd65535}, 24'd65535, 4'd2);

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(bus.abs_ready), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_sad_out", 64'(bus.sad_out), 64'd0);
        check("reset_best_sad", 64'(bus.best_sad), 64'd0);
        check("reset_best_idx", 64'(bus.best_idx), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) run_search($sformatf("tbl%0d", i), tbl[i], 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N_SAMP; i++)
                flat[(N_SAMP-1-i)*DATA_W +: DATA_W] =
                    (r % 2 == 0) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
            rv = model(flat, 2'($urandom_range(0, 2)));
            run_search($sformatf("rand%0d", r), rv, 1'b0, 1'b0);
        end

        // start pulses inside ACCUM and inside the done cycle must be ignored.
        run_search("protocol", tbl[0], 1'b1, 1'b1);

        // Reset while the second candidate is accumulating.
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        send(tbl[0], BLOCK_LEN + 2, 1'b0);
        check("midrst_pre_sad", 64'(bus.sad_out), 64'd10);
        d_base = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_async_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_ready", 64'(bus.abs_ready), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_sad_out", 64'(bus.sad_out), 64'd0);
        check("midrst_best_sad", 64'(bus.best_sad), 64'd0);
        check("midrst_best_idx", 64'(bus.best_idx), 64'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_done", 64'(done_cnt - d_base), 64'd0);
        check("midrst_idle", 64'(bus.busy), 64'd0);
        run_search("after_rst", tbl[0], 1'b0, 1'b0);

        // Saturation on the 17-bit instance: {1,2,3,4} then four 0xFFFF.
        sbus.start = 1'b1;
        @(posedge clk);
        #1;
        sbus.start = 1'b0;
        sat_idx = 0;
        sat_cyc = 0;
        while (sat_idx < SAT_CAND * BLOCK_LEN && sat_cyc < 100) begin
            sbus.abs_valid = 1'b1;
            sbus.abs_in    = (sat_idx < BLOCK_LEN) ? DATA_W'(sat_idx + 1) : 16'hFFFF;
            sat_took       = sbus.abs_ready;
            @(posedge clk);
            #1;
            if (sat_took) sat_idx++;
            sat_cyc++;
        end
        sbus.abs_valid = 1'b0;
        check("sat_beats", 64'(sat_idx), 64'(SAT_CAND * BLOCK_LEN));
        @(posedge clk);
        #1;
        check("sat_done", 64'(sbus.done), 64'd1);
        check("sat_sad_out", 64'(sbus.sad_out), 64'h1FFFF);
        check("sat_best_sad", 64'(sbus.best_sad), 64'd10);
        check("sat_best_idx", 64'(sbus.best_idx), 64'd0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
